// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the clock mode/time-set controller: state codes,
// blink field masks and mode LED patterns.
package clock_ctrl_pkg;

  localparam logic [2:0] ST_RUN   = 3'd0;
  localparam logic [2:0] ST_PAUSE = 3'd1;
  localparam logic [2:0] ST_SET_H = 3'd2;
  localparam logic [2:0] ST_SET_M = 3'd3;
  localparam logic [2:0] ST_SET_S = 3'd4;

  typedef enum logic [2:0] {
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_SET_H = ST_SET_H,
    S_SET_M = ST_SET_M,
    S_SET_S = ST_SET_S
  } state_e;

  // blink_mask bit order {h2,h1,m2,m1,s2,s1}
  localparam logic [5:0] MASK_H = 6'b110000;
  localparam logic [5:0] MASK_M = 6'b001100;
  localparam logic [5:0] MASK_S = 6'b000011;

  // mode_led one-hot {SET_S,SET_M,SET_H,RUN}
  localparam logic [3:0] LED_RUN   = 4'b0001;
  localparam logic [3:0] LED_SET_H = 4'b0010;
  localparam logic [3:0] LED_SET_M = 4'b0100;
  localparam logic [3:0] LED_SET_S = 4'b1000;
  localparam logic [3:0] LED_PAUSE = 4'b0000;

  function automatic logic is_set(input state_e s);
    return (s == S_SET_H) || (s == S_SET_M) || (s == S_SET_S);
  endfunction

  function automatic logic [5:0] field_mask(input state_e s);
    case (s)
      S_SET_H: return MASK_H;
      S_SET_M: return MASK_M;
      S_SET_S: return MASK_S;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [3:0] led_of(input state_e s);
    case (s)
      S_RUN:   return LED_RUN;
      S_SET_H: return LED_SET_H;
      S_SET_M: return LED_SET_M;
      S_SET_S: return LED_SET_S;
      default: return LED_PAUSE;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..PERIOD-1 counter with synchronous clear; tick_o is high
// for the single cycle in which the counter sits at its last value.
module tick_gen #(
  parameter int PERIOD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/pause and time-set controller: turns debounced key pulses into the
// counter run level, field increment pulses, digit blink mask and mode LEDs.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BLINK_CYC = 12_500_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       key_run,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       cnt_run,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [5:0] blink_mask,
  output logic [3:0] mode_led
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_S);

  state_e     state_q, state_d;
  logic [2:0] inc_q, inc_d;          // {hour,min,sec}
  logic       phase_q, phase_d;      // 1 = blank half of the blink period
  logic [7:0] idle_q, idle_d;
  logic       cnt_run_q, cnt_run_d;
  logic [5:0] mask_q, mask_d;
  logic [3:0] led_q, led_d;

  logic blink_tick, sec_tick, blk_clr, tmo_clr, timeout, entering;

  tick_gen #(.PERIOD(BLINK_CYC)) u_blink (
    .clk    (CLK_50M),
    .rst_n  (RST_N),
    .clr_i  (blk_clr),
    .tick_o (blink_tick)
  );

  tick_gen #(.PERIOD(CLK_FREQ)) u_sec (
    .clk    (CLK_50M),
    .rst_n  (RST_N),
    .clr_i  (tmo_clr),
    .tick_o (sec_tick)
  );

  // Timeout shares key_run's destination, so it outranks key_mode and key_inc.
  always_comb begin
    state_d = state_q;
    inc_d   = 3'b000;
    timeout = is_set(state_q) && (idle_q == TMO);
    case (state_q)
      S_RUN: begin
        if (key_run)       state_d = S_PAUSE;
        else if (key_mode) state_d = S_SET_H;
      end
      S_PAUSE: begin
        if (key_run)       state_d = S_RUN;
        else if (key_mode) state_d = S_SET_H;
      end
      S_SET_H: begin
        if (key_run || timeout) state_d = S_RUN;
        else if (key_mode)      state_d = S_SET_M;
        else if (key_inc)       inc_d   = 3'b100;
      end
      S_SET_M: begin
        if (key_run || timeout) state_d = S_RUN;
        else if (key_mode)      state_d = S_SET_S;
        else if (key_inc)       inc_d   = 3'b010;
      end
      S_SET_S: begin
        if (key_run || timeout) state_d = S_RUN;
        else if (key_mode)      state_d = S_RUN;
        else if (key_inc)       inc_d   = 3'b001;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Blink phase and idle timer restart on SET entry; outside SET they are held clear.
  always_comb begin
    entering = (state_d != state_q);
    blk_clr  = !is_set(state_d) || entering || (inc_d != 3'b000);
    tmo_clr  = !is_set(state_d) || entering || key_run || key_mode || key_inc;

    phase_d = phase_q;
    if (blk_clr)         phase_d = 1'b0;
    else if (blink_tick) phase_d = ~phase_q;

    idle_d = idle_q;
    if (tmo_clr)                         idle_d = 8'd0;
    else if (sec_tick && (idle_q < TMO)) idle_d = idle_q + 8'd1;

    cnt_run_d = (state_d == S_RUN);
    mask_d    = phase_d ? field_mask(state_d) : 6'b000000;
    led_d     = led_of(state_d);
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_RUN;
      inc_q     <= 3'b000;
      phase_q   <= 1'b0;
      idle_q    <= 8'd0;
      cnt_run_q <= 1'b1;
      mask_q    <= 6'b000000;
      led_q     <= LED_RUN;
    end else begin
      state_q   <= state_d;
      inc_q     <= inc_d;
      phase_q   <= phase_d;
      idle_q    <= idle_d;
      cnt_run_q <= cnt_run_d;
      mask_q    <= mask_d;
      led_q     <= led_d;
    end
  end

  assign cnt_run    = cnt_run_q;
  assign inc_hour   = inc_q[2];
  assign inc_min    = inc_q[1];
  assign inc_sec    = inc_q[0];
  assign blink_mask = mask_q;
  assign mode_led   = led_q;

endmodule
